box_plotter: RTL and testbench

BOX_PLOTTER -- requirements
Module: box_plotter

---
 rtl/draw_pkg.sv | 17 +
 rtl/xy_scan.sv | 51 +++++
 rtl/box_plotter.sv | 146 ++++++++++++++
 tb/tb_box_plotter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared constants and FSM state type for the box plotter and its scan counter.
package draw_pkg;

  localparam int unsigned SCR_W_DEF = 160;
  localparam int unsigned SCR_H_DEF = 120;
  localparam int unsigned X_W       = 8;
  localparam int unsigned Y_W       = 7;
  localparam int unsigned C_W       = 3;

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StClear,
    StDone
  } state_e;

endpackage

// File: rtl/xy_scan.sv
// Row-major 2-D wrap counter; exposes next-cycle coordinates so the caller can register pixels.
module xy_scan
  import draw_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clr_i,
  input  logic           en_i,
  input  logic [X_W-1:0] w_i,
  input  logic [Y_W-1:0] h_i,
  output logic [X_W-1:0] cx_nxt_o,
  output logic [Y_W-1:0] cy_nxt_o,
  output logic           last_o
);

  logic [X_W-1:0] cx_q, cx_d;
  logic [Y_W-1:0] cy_q, cy_d;
  logic           x_end, y_end;

  assign x_end  = (cx_q == w_i - X_W'(1));
  assign y_end  = (cy_q == h_i - Y_W'(1));
  assign last_o = x_end && y_end;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clr_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (en_i) begin
      cx_d = x_end ? '0 : cx_q + X_W'(1);
      if (x_end) begin
        cy_d = y_end ? '0 : cy_q + Y_W'(1);
      end
    end
  end

  assign cx_nxt_o = cx_d;
  assign cy_nxt_o = cy_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

endmodule

// File: rtl/box_plotter.sv
// Draws a clipped BOX_W x BOX_H box or clears the screen, one registered pixel per cycle.
module box_plotter
  import draw_pkg::*;
#(
  parameter int unsigned BOX_W = 4,
  parameter int unsigned BOX_H = 4,
  parameter int unsigned SCR_W = SCR_W_DEF,
  parameter int unsigned SCR_H = SCR_H_DEF
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           draw_go,
  input  logic           clear_go,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  input  logic [C_W-1:0] colour_in,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [C_W-1:0] colour_out,
  output logic           plot,
  output logic           busy,
  output logic           done
);

  localparam logic [X_W-1:0] BoxWLim = X_W'(BOX_W);
  localparam logic [Y_W-1:0] BoxHLim = Y_W'(BOX_H);
  localparam logic [X_W-1:0] ScrWLim = X_W'(SCR_W);
  localparam logic [Y_W-1:0] ScrHLim = Y_W'(SCR_H);

  state_e         state_q, state_d;
  logic [X_W-1:0] org_x_q, org_x_d;
  logic [Y_W-1:0] org_y_q, org_y_d;
  logic [C_W-1:0] col_q, col_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [C_W-1:0] cout_q, cout_d;
  logic           plot_q, plot_d;

  logic           scan_clr, scan_en, scan_last;
  logic [X_W-1:0] w_lim, cx_nxt;
  logic [Y_W-1:0] h_lim, cy_nxt;
  logic [X_W:0]   sum_x;
  logic [Y_W:0]   sum_y;

  xy_scan u_scan (
    .clk_i    (clk),
    .rst_ni   (resetn),
    .clr_i    (scan_clr),
    .en_i     (scan_en),
    .w_i      (w_lim),
    .h_i      (h_lim),
    .cx_nxt_o (cx_nxt),
    .cy_nxt_o (cy_nxt),
    .last_o   (scan_last)
  );

  always_comb begin
    state_d  = state_q;
    org_x_d  = org_x_q;
    org_y_d  = org_y_q;
    col_d    = col_q;
    scan_clr = 1'b0;
    scan_en  = 1'b0;
    w_lim    = BoxWLim;
    h_lim    = BoxHLim;
    unique case (state_q)
      StIdle: begin
        scan_clr = 1'b1;
        if (clear_go) begin
          state_d = StClear;
        end else if (draw_go) begin
          state_d = StDraw;
          org_x_d = x_in;
          org_y_d = y_in;
          col_d   = colour_in;
        end
      end
      StDraw: begin
        scan_en = 1'b1;
        if (scan_last) state_d = StDone;
      end
      StClear: begin
        scan_en = 1'b1;
        w_lim   = ScrWLim;
        h_lim   = ScrHLim;
        if (scan_last) state_d = StDone;
      end
      StDone: begin
        scan_clr = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Pixel registers are loaded from next-cycle state/counters so each pixel lines up with its scan cycle.
  assign sum_x = {1'b0, org_x_d} + {1'b0, cx_nxt};
  assign sum_y = {1'b0, org_y_d} + {1'b0, cy_nxt};

  always_comb begin
    x_d    = '0;
    y_d    = '0;
    cout_d = '0;
    plot_d = 1'b0;
    if (state_d == StDraw) begin
      x_d    = sum_x[X_W-1:0];
      y_d    = sum_y[Y_W-1:0];
      cout_d = col_d;
      plot_d = (sum_x < (X_W+1)'(SCR_W)) && (sum_y < (Y_W+1)'(SCR_H));
    end else if (state_d == StClear) begin
      x_d    = cx_nxt;
      y_d    = cy_nxt;
      plot_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      org_x_q <= '0;
      org_y_q <= '0;
      col_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cout_q  <= '0;
      plot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      org_x_q <= org_x_d;
      org_y_q <= org_y_d;
      col_q   <= col_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
      plot_q  <= plot_d;
    end
  end

  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour_out = cout_q;
  assign plot       = plot_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_box_plotter.sv
// Checks box_plotter against a per-cycle queue of expected pixels built from the box/clear rules.
module tb_box_plotter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       draw_go = 1'b0;
  logic       clear_go = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [2:0] colour_in = '0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot, busy, done;

  always #5 clk = ~clk;

  box_plotter dut (
    .clk        (clk),
    .resetn     (resetn),
    .draw_go    (draw_go),
    .clear_go   (clear_go),
    .x_in       (x_in),
    .y_in       (y_in),
    .colour_in  (colour_in),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    bit plot;
    int x;
    int y;
    int c;
    bit busy;
    bit done;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int n_plot = 0, n_busy = 0, n_done = 0, last_x = 0, last_y = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // One entry per busy cycle: the scan pixels, then the done cycle.
  function automatic void push_op(bit is_clr, int ox, int oy, int oc);
    exp_t e;
    int w = is_clr ? 160 : 4;
    int h = is_clr ? 120 : 4;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        e.busy = 1'b1;
        e.done = 1'b0;
        if (is_clr) begin
          e.x = c; e.y = r; e.c = 0; e.plot = 1'b1;
        end else begin
          e.x = ox + c; e.y = oy + r; e.c = oc;
          e.plot = (e.x < 160) && (e.y < 120);
        end
        q.push_back(e);
      end
    end
    e.plot = 1'b0; e.x = 0; e.y = 0; e.c = 0; e.busy = 1'b1; e.done = 1'b1;
    q.push_back(e);
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) q.delete();
    else if (q.size() != 0) void'(q.pop_front());
    else if (clear_go) push_op(1'b1, 0, 0, 0);
    else if (draw_go) push_op(1'b0, int'(x_in), int'(y_in), int'(colour_in));
  end

  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      if (q.size() != 0) e = q[0];
      else begin
        e.plot = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.x = 0; e.y = 0; e.c = 0;
      end
      chk("plot", int'(plot), int'(e.plot));
      chk("busy", int'(busy), int'(e.busy));
      chk("done", int'(done), int'(e.done));
      if (e.plot) begin
        chk("x_out", int'(x_out), e.x);
        chk("y_out", int'(y_out), e.y);
        chk("colour_out", int'(colour_out), e.c);
      end
      if (plot) begin
        n_plot++;
        last_x = int'(x_out);
        last_y = int'(y_out);
      end
      if (busy) n_busy++;
      if (done) n_done++;
    end
  end

  task automatic launch(bit dg, bit cg, int x, int y, int c, int hold);
    @(posedge clk);
    #1;
    x_in = 8'(x); y_in = 7'(y); colour_in = 3'(c);
    draw_go = dg; clear_go = cg;
    repeat (hold) @(posedge clk);
    #1;
    draw_go = 1'b0; clear_go = 1'b0;
  endtask

  task automatic wait_idle(int bound, string name);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout after %0d cycles, required completion", name, n);
    end
    @(negedge clk);
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_x"}, int'(x_out), 0);
    chk({tag, "_y"}, int'(y_out), 0);
    chk({tag, "_colour"}, int'(colour_out), 0);
    chk({tag, "_plot"}, int'(plot), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int p0, b0, d0;
    #12;
    chk_zero_outputs("reset");
    #5 resetn = 1'b1;

    // Basic box
    p0 = n_plot; b0 = n_busy; d0 = n_done;
    launch(1'b1, 1'b0, 10, 20, 5, 1);
    wait_idle(100, "box_wait");
    chk("box_plots", n_plot - p0, 16);
    chk("box_busy", n_busy - b0, 17);
    chk("box_done", n_done - d0, 1);
    chk("box_last_x", last_x, 13);
    chk("box_last_y", last_y, 23);

    // Corner clipping
    p0 = n_plot; b0 = n_busy; d0 = n_done;
    launch(1'b1, 1'b0, 158, 118, 6, 1);
    wait_idle(100, "clip_wait");
    chk("clip_plots", n_plot - p0, 4);
    chk("clip_busy", n_busy - b0, 17);
    chk("clip_done", n_done - d0, 1);
    chk("clip_last_x", last_x, 159);
    chk("clip_last_y", last_y, 119);

    // Clear wins over draw
    p0 = n_plot; b0 = n_busy; d0 = n_done;
    launch(1'b1, 1'b1, 5, 5, 7, 1);
    wait_idle(20000, "clear_wait");
    chk("clear_plots", n_plot - p0, 19200);
    chk("clear_busy", n_busy - b0, 19201);
    chk("clear_done", n_done - d0, 1);
    chk("clear_last_x", last_x, 159);
    chk("clear_last_y", last_y, 119);

    // Re-pulse during DRAW is ignored
    p0 = n_plot; d0 = n_done;
    launch(1'b1, 1'b0, 50, 60, 3, 1);
    repeat (4) @(posedge clk);
    #1 draw_go = 1'b1;
    @(posedge clk);
    #1 draw_go = 1'b0;
    wait_idle(100, "repulse_wait");
    chk("repulse_plots", n_plot - p0, 16);
    chk("repulse_done", n_done - d0, 1);

    // Asynchronous reset during pixel 7
    p0 = n_plot; d0 = n_done;
    launch(1'b1, 1'b0, 30, 40, 2, 1);
    repeat (6) @(posedge clk);
    #3 resetn = 1'b0;
    #1 chk_zero_outputs("abort");
    @(negedge clk);
    #2 resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_plots", n_plot - p0, 6);
    chk("abort_done", n_done - d0, 0);
    p0 = n_plot; d0 = n_done;
    launch(1'b1, 1'b0, 30, 40, 2, 1);
    wait_idle(100, "fresh_wait");
    chk("fresh_plots", n_plot - p0, 16);
    chk("fresh_done", n_done - d0, 1);

    // Random draws, origin jitter while busy, occasional stray go pulses
    for (int i = 0; i < 40; i++) begin
      int rx, ry;
      if ($urandom_range(0, 3) == 0) begin
        rx = $urandom_range(150, 255);
        ry = $urandom_range(110, 127);
      end else begin
        rx = $urandom_range(0, 255);
        ry = $urandom_range(0, 127);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      launch(1'b1, 1'b0, rx, ry, $urandom_range(0, 7), $urandom_range(1, 3));
      @(posedge clk);
      #1;
      x_in = 8'($urandom);
      y_in = 7'($urandom);
      colour_in = 3'($urandom);
      draw_go = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1 draw_go = 1'b0;
      wait_idle(100, "rand_wait");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
